// File: rtl/obstacle_scheduler_if.sv
// Handshake/bus bundle between the game-flow scheduler and its environment.
// Latency: none (wires only).
// Backpressure: none; slot availability is signalled through slot_busy.
//
// Signals:
//   game_en    : one-clk game tick enable
//   start      : one-clk start pulse
//   collision  : collision level from the detector
//   slot_busy  : per-slot busy flags
//   spawn_req  : one-hot, one-clk spawn pulse per slot
//   amplitude  : arc amplitude for the slot just granted
//   level      : current difficulty level
//   game_over  : high while the game is over
//   running    : high while the game runs
interface obstacle_scheduler_if;
    logic       game_en;
    logic       start;
    logic       collision;
    logic [3:0] slot_busy;
    logic [3:0] spawn_req;
    logic [9:0] amplitude;
    logic [3:0] level;
    logic       game_over;
    logic       running;

    // Environment side: drives ticks, button and collision, observes spawns.
    modport master (
        output game_en, start, collision, slot_busy,
        input  spawn_req, amplitude, level, game_over, running
    );

    // Scheduler side.
    modport slave (
        input  game_en, start, collision, slot_busy,
        output spawn_req, amplitude, level, game_over, running
    );
endinterface

// File: rtl/obstacle_scheduler.sv
// Spawn sequencer for four obstacle slots: paces spawns, picks a free slot round-robin, ramps difficulty.
// Latency: spawn_req/amplitude appear one clk after the deciding game_en cycle; all outputs registered.
// Backpressure: when every slot is busy, the grant is held off and retried on each following tick.
//
// Ports:
//   clk : system clock
//   rst : asynchronous, active-low reset
//   bus : obstacle_scheduler_if.slave (game_en, start, collision, slot_busy in;
//         spawn_req, amplitude, level, game_over, running out)
module obstacle_scheduler #(
    parameter logic [7:0]  BASE_GAP         = 8'd24,
    parameter logic [7:0]  MIN_GAP          = 8'd6,
    parameter logic [7:0]  GAP_STEP         = 8'd2,
    parameter logic [7:0]  SPAWNS_PER_LEVEL = 8'd8,
    parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       rst,
    obstacle_scheduler_if.slave        bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_OVER = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [15:0] lfsr;
    logic [15:0] lfsr_nxt;
    logic [7:0]  gap_cnt;
    logic [7:0]  cur_gap;
    logic [7:0]  lvl_cnt;
    logic [1:0]  rr_ptr;

    logic        start_go;
    logic        tick_run;
    logic        grant_vld;
    logic [1:0]  grant_idx;
    logic [1:0]  cand;
    logic [8:0]  gap_sub;
    logic [7:0]  gap_dec;

    // ------------------------------------------------------------------
    // Game-flow FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start_go  = 1'b0;
        tick_run  = 1'b0;
        case (state)
            S_IDLE, S_OVER: begin
                // start beats a simultaneous collision outside RUN
                if (bus.start) begin
                    state_nxt = S_RUN;
                    start_go  = 1'b1;
                end
            end
            S_RUN: begin
                // collision preempts any tick in the same cycle
                if (bus.collision) begin
                    state_nxt = S_OVER;
                end else if (bus.game_en) begin
                    tick_run = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Slot pick: first free slot starting at rr_ptr. Scanning from the
    // far end down lets the nearest free slot overwrite the others.
    // ------------------------------------------------------------------
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 2'd0;
        cand      = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            cand = rr_ptr + 2'(i);
            if (!bus.slot_busy[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Gap shrink in 9 bits so a step larger than the gap cannot wrap.
    always_comb begin
        gap_sub = {1'b0, cur_gap} - {1'b0, GAP_STEP};
        if (gap_sub[8] || (gap_sub[7:0] < MIN_GAP)) begin
            gap_dec = MIN_GAP;
        end else begin
            gap_dec = gap_sub[7:0];
        end
    end

    // Galois LFSR, right shift, taps 16'hB400.
    always_comb begin
        lfsr_nxt = {1'b0, lfsr[15:1]};
        if (lfsr[0]) begin
            lfsr_nxt = lfsr_nxt ^ 16'hB400;
        end
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr          <= LFSR_SEED;
            gap_cnt       <= BASE_GAP;
            cur_gap       <= BASE_GAP;
            lvl_cnt       <= 8'd0;
            rr_ptr        <= 2'd0;
            bus.spawn_req <= 4'd0;
            bus.amplitude <= 10'd0;
            bus.level     <= 4'd0;
            bus.game_over <= 1'b0;
            bus.running   <= 1'b0;
        end else begin
            lfsr          <= lfsr_nxt;
            bus.spawn_req <= 4'd0;
            bus.running   <= (state_nxt == S_RUN);
            bus.game_over <= (state_nxt == S_OVER);

            if (start_go) begin
                // LFSR deliberately keeps running across restarts
                gap_cnt   <= BASE_GAP;
                cur_gap   <= BASE_GAP;
                lvl_cnt   <= 8'd0;
                rr_ptr    <= 2'd0;
                bus.level <= 4'd0;
            end else if (tick_run) begin
                if (gap_cnt != 8'd0) begin
                    gap_cnt <= gap_cnt - 8'd1;
                end else if (grant_vld) begin
                    bus.spawn_req <= 4'b0001 << grant_idx;
                    bus.amplitude <= {3'b000, lfsr[6:0]};
                    rr_ptr        <= grant_idx + 2'd1;
                    if (lvl_cnt == SPAWNS_PER_LEVEL - 8'd1) begin
                        lvl_cnt <= 8'd0;
                        if (bus.level != 4'hF) begin
                            bus.level <= bus.level + 4'd1;
                        end
                        cur_gap <= gap_dec;
                        gap_cnt <= gap_dec;
                    end else begin
                        lvl_cnt <= lvl_cnt + 8'd1;
                        gap_cnt <= cur_gap;
                    end
                end
                // all slots busy: gap_cnt stays 0, retry on next tick
            end
        end
    end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler: start-up pacing, round-robin, all-busy retry,
// difficulty ramp, collision/restart and mid-RUN reset.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_obstacle_scheduler;

    logic clk;
    logic rst;

    obstacle_scheduler_if bus();

    obstacle_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int idle_clks = 3;

    // Independent model of the free-running amplitude source.
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge rst) begin
        if (!rst) m_lfsr <= 16'hACE1;
        else      m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One game tick followed by idle clocks; returns the spawn_req seen after the tick
    // and the amplitude a grant on this tick must carry.
    task automatic do_tick(input logic coll, output logic [3:0] sr, output logic [9:0] ae);
        bus.game_en   = 1'b1;
        bus.collision = coll;
        ae = {3'b000, m_lfsr[6:0]};
        @(negedge clk);
        bus.game_en   = 1'b0;
        bus.collision = 1'b0;
        sr = bus.spawn_req;
        repeat (idle_clks) @(negedge clk);
    endtask

    // Ticks until a grant appears; ticks = max+1 if none within the bound.
    task automatic run_to_grant(input int max, output int ticks, output logic [3:0] sr,
                                output logic [9:0] ae);
        ticks = max + 1;
        sr    = 4'd0;
        ae    = 10'd0;
        for (int t = 1; t <= max; t++) begin
            do_tick(1'b0, sr, ae);
            if (sr != 4'd0) begin
                ticks = t;
                break;
            end
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] sr;
        logic [3:0] acc;
        logic [9:0] ae;
        logic [9:0] last_amp;
        int         ticks;
        int         exp_gap;
        int         exp_lvl;

        rst           = 1'b0;
        bus.game_en   = 1'b0;
        bus.start     = 1'b0;
        bus.collision = 1'b0;
        bus.slot_busy = 4'd0;
        repeat (2) @(negedge clk);

        check("rst_spawn_req", 32'(bus.spawn_req), 32'h0);
        check("rst_amplitude", 32'(bus.amplitude), 32'h0);
        check("rst_level",     32'(bus.level),     32'h0);
        check("rst_game_over", 32'(bus.game_over), 32'h0);
        check("rst_running",   32'(bus.running),   32'h0);

        rst = 1'b1;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("start_running", 32'(bus.running), 32'h1);

        // First grant: 24 silent ticks, grant on tick 25 into slot 0.
        acc = 4'd0;
        for (int t = 0; t < 24; t++) begin
            do_tick(1'b0, sr, ae);
            acc |= sr;
        end
        check("first_no_early", 32'(acc), 32'h0);
        do_tick(1'b0, sr, ae);
        check("first_grant", 32'(sr), 32'h1);
        check("first_amp", 32'(bus.amplitude), 32'(ae));
        check("first_level", 32'(bus.level), 32'h0);
        check("pulse_one_clk", 32'(bus.spawn_req), 32'h0);

        idle_clks = 1;

        // Round-robin from rr_ptr=1 with slot 1 busy.
        bus.slot_busy = 4'b0010;
        run_to_grant(40, ticks, sr, ae);
        check("rr_ticks", 32'(ticks), 32'd25);
        check("rr_grant", 32'(sr), 32'h4);
        check("rr_amp", 32'(bus.amplitude), 32'(ae));

        // rr_ptr now 3: all free picks slot 3.
        bus.slot_busy = 4'b0000;
        run_to_grant(40, ticks, sr, ae);
        check("rr3_grant", 32'(sr), 32'h8);

        // All busy: 24 drain ticks plus 5 retries with no grant, then release slot 3.
        bus.slot_busy = 4'b1111;
        acc = 4'd0;
        for (int t = 0; t < 29; t++) begin
            do_tick(1'b0, sr, ae);
            acc |= sr;
        end
        check("busy_no_grant", 32'(acc), 32'h0);
        bus.slot_busy = 4'b0111;
        do_tick(1'b0, sr, ae);
        check("busy_release", 32'(sr), 32'h8);
        check("busy_amp", 32'(bus.amplitude), 32'(ae));
        bus.slot_busy = 4'b0000;

        // Difficulty ramp: grants 5..128, slots rotate 0,1,2,3.
        exp_gap = 24;
        for (int k = 5; k <= 128; k++) begin
            run_to_grant(40, ticks, sr, ae);
            check("ramp_ticks", 32'(ticks), 32'(exp_gap + 1));
            check("ramp_slot", 32'(sr), 32'(4'b0001 << ((k - 1) % 4)));
            check("ramp_amp", 32'(bus.amplitude), 32'(ae));
            if (k % 8 == 0) exp_gap = (exp_gap - 2 < 6) ? 6 : exp_gap - 2;
            exp_lvl = (k / 8 > 15) ? 15 : k / 8;
            check("ramp_level", 32'(bus.level), 32'(exp_lvl));
            if (k == 8)   check("level_at_8",   32'(bus.level), 32'd1);
            if (k == 80)  check("level_at_80",  32'(bus.level), 32'd10);
            if (k == 128) check("level_at_128", 32'(bus.level), 32'd15);
        end
        last_amp = bus.amplitude;

        // gap_cnt now 6: drain, then collide on the due tick.
        acc = 4'd0;
        for (int t = 0; t < 6; t++) begin
            do_tick(1'b0, sr, ae);
            acc |= sr;
        end
        check("pre_coll_quiet", 32'(acc), 32'h0);
        do_tick(1'b1, sr, ae);
        check("coll_no_grant", 32'(sr), 32'h0);
        check("coll_game_over", 32'(bus.game_over), 32'h1);
        check("coll_running", 32'(bus.running), 32'h0);
        check("over_amp_hold", 32'(bus.amplitude), 32'(last_amp));
        do_tick(1'b0, sr, ae);
        check("over_no_spawn", 32'(sr), 32'h0);
        check("over_level_hold", 32'(bus.level), 32'd15);

        // start + collision together in OVER: start wins.
        bus.start     = 1'b1;
        bus.collision = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.collision = 1'b0;
        check("restart_running", 32'(bus.running), 32'h1);
        check("restart_over", 32'(bus.game_over), 32'h0);
        check("restart_level", 32'(bus.level), 32'h0);
        run_to_grant(40, ticks, sr, ae);
        check("restart_ticks", 32'(ticks), 32'd25);
        check("restart_grant", 32'(sr), 32'h1);

        // Reset during the deciding cycle: the pulse never appears.
        acc = 4'd0;
        for (int t = 0; t < 24; t++) begin
            do_tick(1'b0, sr, ae);
            acc |= sr;
        end
        check("prerst_quiet", 32'(acc), 32'h0);
        bus.game_en = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        bus.game_en = 1'b0;
        check("mrst_spawn_req", 32'(bus.spawn_req), 32'h0);
        check("mrst_amplitude", 32'(bus.amplitude), 32'h0);
        check("mrst_level",     32'(bus.level),     32'h0);
        check("mrst_game_over", 32'(bus.game_over), 32'h0);
        check("mrst_running",   32'(bus.running),   32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_spawn", 32'(bus.spawn_req), 32'h0);
        check("post_rst_idle", 32'(bus.running), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
